// File: rtl/rggen_ext_bus_pkg.sv
// Shared definitions for the register-interface to external-bus bridge.
// Latency: n/a (declarations only).
// Backpressure: n/a.
// Contents: FSM state encoding, response status codes, access codes.
package rggen_ext_bus_pkg;

  typedef enum logic [1:0] {
    STATE_IDLE = 2'd0,
    STATE_BUSY = 2'd1,
    STATE_DONE = 2'd2
  } state_e;

  localparam logic [1:0] STATUS_OKAY   = 2'b00;
  localparam logic [1:0] STATUS_SLVERR = 2'b10;

  localparam logic [1:0] ACCESS_READ  = 2'b10;
  localparam logic [1:0] ACCESS_WRITE = 2'b11;

  function automatic logic is_write(input logic [1:0] access);
    return access == ACCESS_WRITE;
  endfunction

endpackage

// File: rtl/rggen_timeout_counter.sv
// Counts enabled cycles and flags the last permitted one.
// Latency: o_expire is combinational on the current count and i_enable.
// Backpressure: none; the counter saturates at LIMIT-1 until cleared.
// Ports: i_clk, i_rst (sync, active-high), i_clear (restart at 0),
//        i_enable (count this cycle), o_expire (this is cycle LIMIT-1).
module rggen_timeout_counter
  import rggen_ext_bus_pkg::*;
#(
  parameter int LIMIT = 256,
  parameter int WIDTH = (LIMIT > 0) ? $clog2(LIMIT + 1) : 1
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_clear,
  input  logic i_enable,
  output logic o_expire
);

  localparam logic [WIDTH-1:0] LAST = (LIMIT > 0) ? WIDTH'(LIMIT - 1) : '0;

  logic [WIDTH-1:0] count_q;

  // Clear wins over enable so a new access always starts from zero.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      count_q <= '0;
    end else if (i_clear) begin
      count_q <= '0;
    end else if (i_enable && (count_q != LAST)) begin
      count_q <= count_q + 1'b1;
    end
  end

  // LIMIT of zero disables the timeout entirely.
  generate
    if (LIMIT > 0) begin : g_expire
      assign o_expire = i_enable && (count_q == LAST);
    end else begin : g_no_expire
      assign o_expire = 1'b0;
    end
  endgenerate

endmodule

// File: rtl/rggen_ext_bus_bridge.sv
// Bridges one register-interface access onto a simple external valid/ready bus.
// Latency: request cycle 0 -> o_ext_valid cycle 1 -> o_register_ready cycle 2 minimum.
// Backpressure: holds the external request until i_ext_ready or the BUSY timeout.
// Ports: i_clk, i_rst (sync, active-high);
//        i_register_* / o_register_* : request and response from the register adapter;
//        o_ext_* / i_ext_*           : request and response on the external bus.
module rggen_ext_bus_bridge
  import rggen_ext_bus_pkg::*;
#(
  parameter int ADDRESS_WIDTH       = 8,
  parameter int LOCAL_ADDRESS_WIDTH = 4,
  parameter int BUS_WIDTH           = 32,
  parameter int START_ADDRESS       = 0,
  parameter int BYTE_SIZE           = 16,
  parameter int TIMEOUT_CYCLES      = 256
) (
  input  logic                           i_clk,
  input  logic                           i_rst,
  input  logic                           i_register_valid,
  input  logic [1:0]                     i_register_access,
  input  logic [ADDRESS_WIDTH-1:0]       i_register_address,
  input  logic [BUS_WIDTH-1:0]           i_register_write_data,
  input  logic [BUS_WIDTH/8-1:0]         i_register_strobe,
  output logic                           o_register_active,
  output logic                           o_register_ready,
  output logic [1:0]                     o_register_status,
  output logic [BUS_WIDTH-1:0]           o_register_read_data,
  output logic                           o_ext_valid,
  output logic                           o_ext_write,
  output logic [LOCAL_ADDRESS_WIDTH-1:0] o_ext_address,
  output logic [BUS_WIDTH-1:0]           o_ext_write_data,
  output logic [BUS_WIDTH/8-1:0]         o_ext_strobe,
  input  logic                           i_ext_ready,
  input  logic [1:0]                     i_ext_status,
  input  logic [BUS_WIDTH-1:0]           i_ext_read_data
);

  // One extra bit so START_ADDRESS+BYTE_SIZE may equal 2**ADDRESS_WIDTH.
  localparam int                   AW1          = ADDRESS_WIDTH + 1;
  localparam logic [AW1-1:0]       WINDOW_START = AW1'(START_ADDRESS);
  localparam logic [AW1-1:0]       WINDOW_END   = AW1'(START_ADDRESS + BYTE_SIZE);
  localparam logic [ADDRESS_WIDTH-1:0] BASE     = ADDRESS_WIDTH'(START_ADDRESS);

  state_e                          state_q, state_d;
  logic                            ext_valid_q, ext_valid_d;
  logic [1:0]                      access_q, access_d;
  logic [LOCAL_ADDRESS_WIDTH-1:0]  address_q, address_d;
  logic [BUS_WIDTH-1:0]            write_data_q, write_data_d;
  logic [BUS_WIDTH/8-1:0]          strobe_q, strobe_d;
  logic [1:0]                      status_q, status_d;
  logic [BUS_WIDTH-1:0]            read_data_q, read_data_d;
  logic                            timer_clear;
  logic                            timer_enable;
  logic                            timer_expire;
  logic [AW1-1:0]                  address_ext;

  // Window decode is purely combinational and ignores state and reset.
  assign address_ext       = {1'b0, i_register_address};
  assign o_register_active = (address_ext >= WINDOW_START) && (address_ext < WINDOW_END);

  rggen_timeout_counter #(
    .LIMIT (TIMEOUT_CYCLES)
  ) u_timeout (
    .i_clk    (i_clk),
    .i_rst    (i_rst),
    .i_clear  (timer_clear),
    .i_enable (timer_enable),
    .o_expire (timer_expire)
  );

  always_comb begin
    state_d      = state_q;
    ext_valid_d  = ext_valid_q;
    access_d     = access_q;
    address_d    = address_q;
    write_data_d = write_data_q;
    strobe_d     = strobe_q;
    status_d     = status_q;
    read_data_d  = read_data_q;
    timer_clear  = 1'b0;
    timer_enable = 1'b0;

    case (state_q)
      STATE_IDLE: begin
        if (i_register_valid && o_register_active) begin
          state_d      = STATE_BUSY;
          // Registered valid rises together with the move into BUSY.
          ext_valid_d  = 1'b1;
          access_d     = i_register_access;
          address_d    = LOCAL_ADDRESS_WIDTH'(i_register_address - BASE);
          write_data_d = i_register_write_data;
          strobe_d     = i_register_strobe;
          timer_clear  = 1'b1;
        end
      end

      STATE_BUSY: begin
        timer_enable = 1'b1;
        // A real completion beats a timeout landing on the same cycle.
        if (i_ext_ready) begin
          state_d     = STATE_DONE;
          ext_valid_d = 1'b0;
          status_d    = i_ext_status;
          read_data_d = is_write(access_q) ? '0 : i_ext_read_data;
        end else if (timer_expire) begin
          state_d     = STATE_DONE;
          ext_valid_d = 1'b0;
          status_d    = STATUS_SLVERR;
          read_data_d = '0;
        end
      end

      STATE_DONE: begin
        state_d = STATE_IDLE;
      end

      default: begin
        state_d     = STATE_IDLE;
        ext_valid_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q      <= STATE_IDLE;
      ext_valid_q  <= 1'b0;
      access_q     <= '0;
      address_q    <= '0;
      write_data_q <= '0;
      strobe_q     <= '0;
      status_q     <= STATUS_OKAY;
      read_data_q  <= '0;
    end else begin
      state_q      <= state_d;
      ext_valid_q  <= ext_valid_d;
      access_q     <= access_d;
      address_q    <= address_d;
      write_data_q <= write_data_d;
      strobe_q     <= strobe_d;
      status_q     <= status_d;
      read_data_q  <= read_data_d;
    end
  end

  // If the adapter has withdrawn its request by DONE, the result is dropped.
  assign o_register_ready     = (state_q == STATE_DONE) && i_register_valid;
  assign o_register_status    = status_q;
  assign o_register_read_data = read_data_q;

  assign o_ext_valid      = ext_valid_q;
  assign o_ext_write      = is_write(access_q);
  assign o_ext_address    = address_q;
  assign o_ext_write_data = write_data_q;
  assign o_ext_strobe     = strobe_q;

endmodule

// File: doc/rggen_ext_bus_bridge.md
RGGEN_EXT_BUS_BRIDGE -- requirements
Module: rggen_ext_bus_bridge

Interface
REQ-001 SHALL have parameter ADDRESS_WIDTH, default 8: width of the incoming register-interface address.
REQ-002 SHALL have parameter LOCAL_ADDRESS_WIDTH, default 4: width of the external-bus address.
REQ-003 SHALL have parameter BUS_WIDTH, default 32: data width; strobe width is BUS_WIDTH/8.
REQ-004 SHALL have parameter START_ADDRESS, default 0: first byte address of the external window.
REQ-005 SHALL have parameter BYTE_SIZE, default 16: window size in bytes.
REQ-006 SHALL have parameter TIMEOUT_CYCLES, default 256: BUSY-cycle limit; 0 disables the timeout.
REQ-007 SHALL have port i_clk, input, 1: the only clock; all logic is on its rising edge.
REQ-008 SHALL have port i_rst, input, 1: reset, synchronous and active-high.
REQ-009 SHALL have port i_register_valid, input, 1: request valid from the adapter; held until ready.
REQ-010 SHALL have port i_register_access, input, 2: 2'b11 write, 2'b10 read.
REQ-011 SHALL have port i_register_address, input, ADDRESS_WIDTH: byte address.
REQ-012 SHALL have port i_register_write_data, input, BUS_WIDTH: write data.
REQ-013 SHALL have port i_register_strobe, input, BUS_WIDTH/8: byte enables.
REQ-014 SHALL have port o_register_active, output, 1: address hit in the window.
REQ-015 SHALL have port o_register_ready, output, 1: access complete.
REQ-016 SHALL have port o_register_status, output, 2: 2'b00 OKAY, 2'b10 SLVERR.
REQ-017 SHALL have port o_register_read_data, output, BUS_WIDTH: read data.
REQ-018 SHALL have port o_ext_valid, output, 1: external request valid.
REQ-019 SHALL have port o_ext_write, output, 1: 1 write, 0 read.
REQ-020 SHALL have port o_ext_address, output, LOCAL_ADDRESS_WIDTH: window-relative address.
REQ-021 SHALL have ports o_ext_write_data (output, BUS_WIDTH) and o_ext_strobe (output, BUS_WIDTH/8): latched write data and strobe.
REQ-022 SHALL have port i_ext_ready, input, 1: external completion.
REQ-023 SHALL have ports i_ext_status (input, 2) and i_ext_read_data (input, BUS_WIDTH): response status and data, sampled with i_ext_ready.

Function
REQ-024 SHALL drive o_register_active combinationally as START_ADDRESS <= i_register_address < START_ADDRESS+BYTE_SIZE, independent of state.
REQ-025 SHALL implement an FSM with states IDLE, BUSY and DONE.
REQ-026 SHALL move IDLE->BUSY on i_register_valid && o_register_active, latching access, address-START_ADDRESS (truncated to LOCAL_ADDRESS_WIDTH), write data and strobe.
REQ-027 SHALL make o_ext_valid a register: high from the cycle after entering BUSY until the cycle i_ext_ready is sampled high, inclusive; it is never high outside BUSY.
REQ-028 SHALL hold all o_ext_* outputs stable while o_ext_valid=1.
REQ-029 SHALL, in BUSY with i_ext_ready=1, capture i_ext_status and i_ext_read_data (data forced to 0 for writes) and go to DONE.
REQ-030 SHALL count BUSY cycles; when the count reaches TIMEOUT_CYCLES-1 without i_ext_ready (TIMEOUT_CYCLES>0), it SHALL drop o_ext_valid, capture status 2'b10 and data 0, and go to DONE.
REQ-031 SHALL give i_ext_ready priority over timeout when both occur in the same cycle.
REQ-032 SHALL assert o_register_ready only in DONE, for exactly one cycle, presenting the captured status and data; DONE->IDLE unconditionally.
REQ-033 SHALL achieve a minimum latency of valid at cycle 0, o_ext_valid at 1, i_ext_ready at 1 and o_register_ready at 2.
REQ-034 SHALL ignore i_register_valid in BUSY and DONE; if valid drops mid-BUSY, the external access SHALL still complete and the result SHALL be discarded in DONE.
REQ-035 SHALL ignore i_ext_ready outside BUSY.

Reset
REQ-036 SHALL, on i_rst=1 at a clock edge, set state IDLE, o_ext_valid 0, o_register_ready 0, status 2'b00, read data 0, latches 0 and counter 0, even mid-transaction.
REQ-037 SHALL require no reset on i_register_* inputs; o_register_active stays combinational during reset.

Structure
REQ-038 SHALL place the state encoding, the status constants OKAY=2'b00 and SLVERR=2'b10, and the access codes in shared package rggen_ext_bus_pkg.
REQ-039 SHALL implement the timeout in one sub-module, rggen_timeout_counter (clear, enable, expire), with a counter width of clog2(TIMEOUT_CYCLES+1).

Verification
REQ-040 SHALL cover a write to 0x04 with data 0xDEADBEEF and strobe 0xF, i_ext_ready at the first o_ext_valid -> o_ext_address 0x4, o_register_ready one cycle later with status 00.
REQ-041 SHALL cover a read of 0x08 with 3 wait cycles and i_ext_read_data 0x12345678 -> o_ext_valid high 4 cycles, then read data 0x12345678 with status 00.
REQ-042 SHALL cover a read of 0x20 (outside the window) -> o_register_active 0 and o_ext_valid never asserted.
REQ-043 SHALL cover TIMEOUT_CYCLES=8 with i_ext_ready never asserted -> o_ext_valid drops, then o_register_ready with status 10 and data 0.
REQ-044 SHALL cover i_rst asserted in BUSY while o_ext_valid=1 -> all outputs at reset values the next cycle, and the next request starts cleanly from IDLE.
REQ-045 SHALL cover i_ext_ready coinciding with the timeout cycle -> the external status and data are returned, not SLVERR.
